// File: rtl/bus_server_pkg.sv
// Shared definitions for request-bus server endpoints: FSM encoding and
// wait-counter width.
package bus_server_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } bus_state_e;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/bus_server_regfile.sv
// Register-file memory for a bus server: async reset to RESET_VALUE, one
// synchronous write port and one registered read port.
module bus_server_regfile #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VALUE;
      rdata_q <= RESET_VALUE;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      // Read data is held between reads so it stays valid for the whole ack phase.
      if (re_i) rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_server_memory.sv
// Bus server responder: accepts one request at a time, inserts WAIT_STATES
// cycles, then serves it from a local register file with a 4-phase rq/ack.
module bus_server_memory
  import bus_server_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] server_address,
  input  logic                  server_rq,
  output logic                  server_ack,
  input  logic                  server_wr_ni,
  input  logic [DATA_WIDTH-1:0] server_dataW,
  output logic [DATA_WIDTH-1:0] server_dataR,
  output logic                  busy,
  output bus_state_e            debug_state
);

  // Handshake: server_rq is a level held by the requester until server_ack=1
  // is seen; the requester then drops rq and ack falls on the edge that
  // samples rq=0. A request is only accepted while IDLE.

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  bus_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ack_q, busy_q;

  logic                  enter_ack;
  logic                  mem_we, mem_re;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_wr;
  logic [DATA_WIDTH-1:0] sel_data;

  // With zero wait states the transaction completes on its acceptance edge,
  // so the live inputs are used there; afterwards only the captured copy.
  assign sel_addr = (state_q == ST_IDLE) ? server_address : addr_q;
  assign sel_wr   = (state_q == ST_IDLE) ? server_wr_ni   : wr_q;
  assign sel_data = (state_q == ST_IDLE) ? server_dataW   : data_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    data_d    = data_q;
    enter_ack = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (server_rq) begin
          addr_d = server_address;
          wr_d   = server_wr_ni;
          data_d = server_dataW;
          if (WAIT_STATES == 0) begin
            enter_ack = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!server_rq) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          enter_ack = 1'b1;
          cnt_d     = '0;
        end
      end
      ST_ACK: begin
        if (!server_rq) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_ack) begin
      state_d = ST_ACK;
      mem_we  = sel_wr;
      mem_re  = !sel_wr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      ack_q   <= (state_d == ST_ACK);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  bus_server_regfile #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_regfile (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (mem_we),
    .waddr_i (sel_addr),
    .wdata_i (sel_data),
    .re_i    (mem_re),
    .raddr_i (sel_addr),
    .rdata_o (server_dataR)
  );

  assign server_ack  = ack_q;
  assign busy        = busy_q;
  assign debug_state = state_q;

endmodule
